// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory and
// queues {pc, word} for decode. Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_stall counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  // 33-bit limit so a memory ending exactly at 2^32 cannot wrap to zero.
  localparam logic [32:0] LIMIT = 33'(RESET_PC) + 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic          busy_q, done_q;
  logic [31:0]   qpc_q   [QDEPTH];
  logic [31:0]   qinstr_q[QDEPTH];

  logic          pop, redir, push, pop_eff, free, tgt_ok;
  logic [31:0]   tgt;
  logic [32:0]   pc_inc;

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? qinstr_q[head_q] : '0;
  assign out_pc    = out_valid ? qpc_q[head_q]    : '0;
  assign imem_addr = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    pop     = out_valid && out_ready;
    redir   = redirect_valid && (state_q != S_IDLE);
    tgt     = {redirect_pc[31:2], 2'b00};
    tgt_ok  = ({1'b0, tgt} < LIMIT) && (tgt >= RESET_PC);
    pc_inc  = {1'b0, pc_q} + 33'd4;
    free    = (count_q < CW'(QDEPTH)) || pop;
    push    = ((state_q == S_RUN) || (state_q == S_FULL)) && free && !redir;
    pop_eff = pop && !redir;

    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q + CW'(push) - CW'(pop_eff);
    head_d  = head_q + AW'(pop_eff);
    tail_d  = tail_q + AW'(push);

    // Redirect outranks push/pop: flush, load the aligned target, and decide RUN vs DONE.
    if (redir) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      pc_d    = tgt;
      state_d = tgt_ok ? S_RUN : S_DONE;
    end else begin
      if (push) pc_d = pc_inc[31:0];
      case (state_q)
        S_IDLE: if (start) state_d = S_RUN;
        S_RUN: begin
          if (push && (pc_inc >= LIMIT))                  state_d = S_DONE;
          else if ((count_q == CW'(QDEPTH)) && !pop)       state_d = S_FULL;
        end
        S_FULL: begin
          if (push && (pc_inc >= LIMIT)) state_d = S_DONE;
          else if (pop)                  state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_FULL);
      done_q  <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[tail_q]    <= pc_q;
      qinstr_q[tail_q] <= imem_rd;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push && (fetched_q != '1))              fetched_q <= fetched_q + 32'd1;
      if ((state_q == S_FULL) && (stall_q != '1)) stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (64-word and 8-word memories)
// sharing clock and reset, checked with immediate assertions against hand-computed values.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, out_ready_a, redirect_valid_a, out_valid_a, busy_a, done_a;
  logic [31:0] imem_addr_a, imem_rd_a, out_instr_a, out_pc_a, redirect_pc_a;
  logic        start_b, out_ready_b, redirect_valid_b, out_valid_b, busy_b, done_b;
  logic [31:0] imem_addr_b, imem_rd_b, out_instr_b, out_pc_b, redirect_pc_b;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_a, perf_stall_a, perf_fetched_b, perf_stall_b;
`endif

  logic [31:0] mem [64];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rd_a = (imem_addr_a < 32'd256) ? mem[imem_addr_a[7:2]] : NOP;
  assign imem_rd_b = (imem_addr_b < 32'd32)  ? mem[imem_addr_b[7:2]] : NOP;

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(64), .QDEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .imem_addr(imem_addr_a), .imem_rd(imem_rd_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_instr(out_instr_a), .out_pc(out_pc_a),
    .redirect_valid(redirect_valid_a), .redirect_pc(redirect_pc_a),
    .busy(busy_a), .done(done_a)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched_a), .perf_stall(perf_stall_a)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(8), .QDEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .imem_addr(imem_addr_b), .imem_rd(imem_rd_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_instr(out_instr_b), .out_pc(out_pc_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .busy(busy_b), .done(done_b)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched_b), .perf_stall(perf_stall_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w [5];
    exp_w[0] = 32'hE3A00001; exp_w[1] = 32'hE3A01002;
    exp_w[2] = 32'hE0802001; exp_w[3] = 32'hE0803002; exp_w[4] = NOP;
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    for (int i = 0; i < 4; i++)  mem[i] = exp_w[i];

    reset = 1'b1;
    start_a = 0; out_ready_a = 0; redirect_valid_a = 0; redirect_pc_a = '0;
    start_b = 0; out_ready_b = 0; redirect_valid_b = 0; redirect_pc_b = '0;

    // Reset state
    #1;
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_addr",  imem_addr_a, 32'h0);
    chk("rst_pc",    out_pc_a, 32'h0);
    chk("rst_instr", out_instr_a, 32'h0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    #6 reset = 1'b0;

    // 1: streaming fetch with out_ready high
    start_a = 1; out_ready_a = 1;
    tick();
    start_a = 0;
    chk("s1_busy", 32'(busy_a), 32'd1);
    chk("s1_valid_lat", 32'(out_valid_a), 32'd0);
    chk("s1_addr0", imem_addr_a, 32'h0);
    tick();
    chk("s1_valid", 32'(out_valid_a), 32'd1);
    chk("s1_pc0", out_pc_a, 32'h0);
    chk("s1_in0", out_instr_a, exp_w[0]);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("s1_pc", out_pc_a, 32'(4 * i));
      chk("s1_in", out_instr_a, exp_w[i]);
    end

    // 2 + 6: backpressure into FULL, stall counting, then release
    pulse_reset();
    out_ready_a = 0; start_a = 1;
    tick();
    start_a = 0;
    tick();
    tick();
    chk("s2_valid", 32'(out_valid_a), 32'd1);
    chk("s2_addr8", imem_addr_a, 32'h8);
    tick();
    chk("s2_busy_full", 32'(busy_a), 32'd1);
    repeat (5) tick();
    chk("s2_hold_addr", imem_addr_a, 32'h8);
    chk("s2_hold_pc", out_pc_a, 32'h0);
    chk("s2_hold_in", out_instr_a, exp_w[0]);
`ifdef FETCH_PERF_CNT_EN
    chk("s6_stall", perf_stall_a, 32'd5);
    chk("s6_fetched", perf_fetched_a, 32'd2);
`endif
    out_ready_a = 1;
    tick();
    chk("s2_pop_pc4", out_pc_a, 32'h4);
    chk("s2_pop_valid", 32'(out_valid_a), 32'd1);
    tick();
    chk("s2_pop_pc8", out_pc_a, 32'h8);

    // 3: redirect to unaligned 0xE while head is pc 8
    redirect_valid_a = 1; redirect_pc_a = 32'h0000000E;
    tick();
    redirect_valid_a = 0;
    chk("s3_flush_valid", 32'(out_valid_a), 32'd0);
    chk("s3_addr", imem_addr_a, 32'hC);
    tick();
    chk("s3_valid", 32'(out_valid_a), 32'd1);
    chk("s3_pc", out_pc_a, 32'hC);
    chk("s3_in", out_instr_a, exp_w[3]);

    // 4: 8-word memory runs to DONE, redirect back in, then redirect to the limit
    start_b = 1; out_ready_b = 1;
    tick();
    start_b = 0;
    tick();
    chk("s4_pc0", out_pc_b, 32'h0);
    repeat (6) tick();
    chk("s4_pc18", out_pc_b, 32'h18);
    chk("s4_busy_run", 32'(busy_b), 32'd1);
    tick();
    chk("s4_pc1c", out_pc_b, 32'h1C);
    chk("s4_done", 32'(done_b), 32'd1);
    chk("s4_busy", 32'(busy_b), 32'd0);
    tick();
    chk("s4_drained", 32'(out_valid_b), 32'd0);
    chk("s4_addr_lim", imem_addr_b, 32'h20);
    redirect_valid_b = 1; redirect_pc_b = 32'h0;
    tick();
    redirect_valid_b = 0;
    chk("s4_rd_busy", 32'(busy_b), 32'd1);
    chk("s4_rd_done", 32'(done_b), 32'd0);
    chk("s4_rd_valid", 32'(out_valid_b), 32'd0);
    tick();
    chk("s4_rd_pc0", out_pc_b, 32'h0);
    chk("s4_rd_v", 32'(out_valid_b), 32'd1);
    redirect_valid_b = 1; redirect_pc_b = 32'h20;
    tick();
    redirect_valid_b = 0;
    chk("s4_lim_done", 32'(done_b), 32'd1);
    chk("s4_lim_valid", 32'(out_valid_b), 32'd0);

    // 5: asynchronous reset mid-RUN with two entries queued
    pulse_reset();
    out_ready_a = 0; start_a = 1;
    tick();
    start_a = 0;
    tick();
    tick();
    chk("s5_pre_valid", 32'(out_valid_a), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("s5_async_valid", 32'(out_valid_a), 32'd0);
    chk("s5_async_addr", imem_addr_a, 32'h0);
    chk("s5_async_busy", 32'(busy_a), 32'd0);
    #2 reset = 1'b0;
    redirect_valid_a = 1; redirect_pc_a = 32'h40;
    tick();
    redirect_valid_a = 0;
    chk("s5_idle_redir", imem_addr_a, 32'h0);
    tick();
    chk("s5_idle_valid", 32'(out_valid_a), 32'd0);
    chk("s5_idle_busy", 32'(busy_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
